// File: rtl/pwm_duty_sorter_pkg.sv
// Shared types and helpers for the sequential PWM duty sorter.
package pwm_sort_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_e;

  // A single channel still needs a 1-bit index field.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/pwm_duty_sorter_if.sv
// Request/result bundle between a PWM register file (master) and the duty sorter (slave).
interface pwm_duty_sorter_if
  import pwm_sort_pkg::*;
#(
  parameter int Resolution = 16,
  parameter int Channels   = 4
);
  localparam int IdxW = idx_w(Channels);

  logic                           start_i;
  logic [Channels*Resolution-1:0] duty_i;
  logic                           busy_o;
  logic                           done_o;
  logic                           valid_o;
  logic [Channels*Resolution-1:0] sorted_duty_o;
  logic [Channels*IdxW-1:0]       sorted_idx_o;
  logic [Resolution-1:0]          min_duty_o;
  logic [Resolution-1:0]          max_duty_o;

  modport master (
    output start_i, duty_i,
    input  busy_o, done_o, valid_o, sorted_duty_o, sorted_idx_o, min_duty_o, max_duty_o
  );

  modport slave (
    input  start_i, duty_i,
    output busy_o, done_o, valid_o, sorted_duty_o, sorted_idx_o, min_duty_o, max_duty_o
  );
endinterface

// File: rtl/pwm_duty_sorter_cmp_swap.sv
// Compare-swap cell: orders one (value, index) pair, swapping only on strictly greater.
module pwm_cmp_swap #(
  parameter int Resolution = 16,
  parameter int IdxW       = 2
) (
  input  logic [Resolution-1:0] a_val_i,
  input  logic [IdxW-1:0]       a_idx_i,
  input  logic [Resolution-1:0] b_val_i,
  input  logic [IdxW-1:0]       b_idx_i,
  output logic [Resolution-1:0] lo_val,
  output logic [IdxW-1:0]       lo_idx,
  output logic [Resolution-1:0] hi_val,
  output logic [IdxW-1:0]       hi_idx,
  output logic                  swapped
);
  assign swapped = (a_val_i > b_val_i);
  assign lo_val  = swapped ? b_val_i : a_val_i;
  assign lo_idx  = swapped ? b_idx_i : a_idx_i;
  assign hi_val  = swapped ? a_val_i : b_val_i;
  assign hi_idx  = swapped ? a_idx_i : b_idx_i;
endmodule

// File: rtl/pwm_duty_sorter.sv
// Odd-even transposition sorter for PWM duty values, one pass per clock.
// Optional macro PWM_SORT_EARLY_EXIT_EN stops after two consecutive swap-free passes.
module pwm_duty_sorter
  import pwm_sort_pkg::*;
#(
  parameter int Resolution = 16,
  parameter int Channels   = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  pwm_duty_sorter_if.slave     bus
);
  localparam int IdxW  = idx_w(Channels);
  localparam int NPair = (Channels < 2) ? 1 : Channels / 2;

  if (Channels < 2) begin : g_bad_channels
    $error("pwm_duty_sorter: Channels must be at least 2");
  end

  state_e                state_q, state_d;
  logic [IdxW-1:0]       pass_q;
  logic                  valid_q;
  logic [Resolution-1:0] val_q [Channels];
  logic [Resolution-1:0] val_d [Channels];
  logic [IdxW-1:0]       idx_q [Channels];
  logic [IdxW-1:0]       idx_d [Channels];
  logic                  last_pass, finish;

  logic [Resolution-1:0] ev_lo_val [NPair];
  logic [Resolution-1:0] ev_hi_val [NPair];
  logic [IdxW-1:0]       ev_lo_idx [NPair];
  logic [IdxW-1:0]       ev_hi_idx [NPair];
  logic [Resolution-1:0] od_lo_val [NPair];
  logic [Resolution-1:0] od_hi_val [NPair];
  logic [IdxW-1:0]       od_lo_idx [NPair];
  logic [IdxW-1:0]       od_hi_idx [NPair];
  logic [NPair-1:0]      ev_sw, od_sw;

  for (genvar k = 0; k < NPair; k++) begin : g_pair
    pwm_cmp_swap #(.Resolution(Resolution), .IdxW(IdxW)) u_even (
      .a_val_i(val_q[2*k]),   .a_idx_i(idx_q[2*k]),
      .b_val_i(val_q[2*k+1]), .b_idx_i(idx_q[2*k+1]),
      .lo_val(ev_lo_val[k]),  .lo_idx(ev_lo_idx[k]),
      .hi_val(ev_hi_val[k]),  .hi_idx(ev_hi_idx[k]),
      .swapped(ev_sw[k])
    );
    if (2*k+2 < Channels) begin : g_odd
      pwm_cmp_swap #(.Resolution(Resolution), .IdxW(IdxW)) u_odd (
        .a_val_i(val_q[2*k+1]), .a_idx_i(idx_q[2*k+1]),
        .b_val_i(val_q[2*k+2]), .b_idx_i(idx_q[2*k+2]),
        .lo_val(od_lo_val[k]),  .lo_idx(od_lo_idx[k]),
        .hi_val(od_hi_val[k]),  .hi_idx(od_hi_idx[k]),
        .swapped(od_sw[k])
      );
    end else begin : g_no_odd
      // Top slot has no odd partner: it passes through unchanged.
      assign od_lo_val[k] = '0;
      assign od_hi_val[k] = '0;
      assign od_lo_idx[k] = '0;
      assign od_hi_idx[k] = '0;
      assign od_sw[k]     = 1'b0;
    end
  end

  always_comb begin
    val_d = val_q;
    idx_d = idx_q;
    for (int k = 0; k < NPair; k++) begin
      if (!pass_q[0]) begin
        val_d[2*k]   = ev_lo_val[k];
        idx_d[2*k]   = ev_lo_idx[k];
        val_d[2*k+1] = ev_hi_val[k];
        idx_d[2*k+1] = ev_hi_idx[k];
      end else if (2*k+2 < Channels) begin
        val_d[2*k+1] = od_lo_val[k];
        idx_d[2*k+1] = od_lo_idx[k];
        val_d[2*k+2] = od_hi_val[k];
        idx_d[2*k+2] = od_hi_idx[k];
      end
    end
  end

  assign last_pass = (pass_q == IdxW'(Channels - 1));

`ifdef PWM_SORT_EARLY_EXIT_EN
  logic any_swap, prev_swap_q;
  assign any_swap = pass_q[0] ? (|od_sw) : (|ev_sw);
  assign finish   = last_pass || ((pass_q != '0) && !any_swap && !prev_swap_q);

  always_ff @(posedge clk_i) begin
    if (rst_i)                                 prev_swap_q <= 1'b0;
    else if (state_q == IDLE && bus.start_i)   prev_swap_q <= 1'b0;
    else if (state_q == SORT)                  prev_swap_q <= any_swap;
  end
`else
  assign finish = last_pass;
`endif

  // ---- state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // ---- next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start_i) state_d = SORT;
      SORT:    if (finish)      state_d = DONE;
      DONE:                     state_d = IDLE;
      default:                  state_d = IDLE;
    endcase
  end

  // ---- working registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pass_q  <= '0;
      valid_q <= 1'b0;
      for (int k = 0; k < Channels; k++) begin
        val_q[k] <= '0;
        idx_q[k] <= IdxW'(k);
      end
    end else begin
      case (state_q)
        IDLE: if (bus.start_i) begin
          pass_q  <= '0;
          valid_q <= 1'b0;
          for (int k = 0; k < Channels; k++) begin
            val_q[k] <= bus.duty_i[k*Resolution +: Resolution];
            idx_q[k] <= IdxW'(k);
          end
        end
        SORT: begin
          val_q <= val_d;
          idx_q <= idx_d;
          if (finish) valid_q <= 1'b1;
          else        pass_q  <= pass_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // ---- outputs
  always_comb begin
    bus.busy_o = (state_q == SORT);
    bus.done_o = (state_q == DONE);
  end

  assign bus.valid_o    = valid_q;
  assign bus.min_duty_o = val_q[0];
  assign bus.max_duty_o = val_q[Channels-1];

  for (genvar k = 0; k < Channels; k++) begin : g_out
    assign bus.sorted_duty_o[k*Resolution +: Resolution] = val_q[k];
    assign bus.sorted_idx_o[k*IdxW +: IdxW]              = idx_q[k];
  end
endmodule

// File: tb/tb_pwm_duty_sorter.sv
// Directed, table-driven bench for pwm_duty_sorter (Channels=4, Resolution=16).
module tb_pwm_duty_sorter;
  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  pwm_duty_sorter_if #(.Resolution(16), .Channels(4)) bus ();

  pwm_duty_sorter #(.Resolution(16), .Channels(4)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

`ifdef PWM_SORT_EARLY_EXIT_EN
  localparam int LAT_SORTED = 3;
  localparam int LAT_NEAR   = 4;
`else
  localparam int LAT_SORTED = 5;
  localparam int LAT_NEAR   = 5;
`endif

  typedef struct {
    string       name;
    logic [63:0] duty;
    logic [63:0] exp_sorted;
    logic [7:0]  exp_idx;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];
  int   nvec = 0;
  int   nerr = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Launch one sort at cycle 0 and return the cycle in which done_o is seen (-1 on timeout).
  task automatic run_sort(input logic [63:0] d, output int lat);
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.duty_i  = d;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    bus.duty_i  = {$urandom, $urandom};
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) check("busy_cycle1", 64'(bus.busy_o), 64'd1);
      if (bus.done_o) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_busy"},  64'(bus.busy_o),  64'd0);
    check({tag, "_done"},  64'(bus.done_o),  64'd0);
    check({tag, "_valid"}, 64'(bus.valid_o), 64'd0);
    check({tag, "_duty"},  bus.sorted_duty_o, 64'd0);
    check({tag, "_idx"},   64'(bus.sorted_idx_o), 64'hE4);
    check({tag, "_min"},   64'(bus.min_duty_o), 64'd0);
    check({tag, "_max"},   64'(bus.max_duty_o), 64'd0);
  endtask

  initial begin
    int lat;
    int ndone;
    int first_done;
    int second_done;

    vecs[0] = '{"mixed_dup", {16'd100, 16'd200, 16'd100, 16'd300},
                {16'd300, 16'd200, 16'd100, 16'd100}, {2'd0, 2'd2, 2'd3, 2'd1}, 5};
    vecs[1] = '{"reverse",   {16'd100, 16'd200, 16'd300, 16'd400},
                {16'd400, 16'd300, 16'd200, 16'd100}, {2'd0, 2'd1, 2'd2, 2'd3}, 5};
    vecs[2] = '{"edges",     {16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF},
                {16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000}, {2'd2, 2'd0, 2'd3, 2'd1}, 5};
    vecs[3] = '{"presorted", {16'd40, 16'd30, 16'd20, 16'd10},
                {16'd40, 16'd30, 16'd20, 16'd10}, 8'hE4, LAT_SORTED};
    vecs[4] = '{"near",      {16'd3, 16'd4, 16'd2, 16'd1},
                {16'd4, 16'd3, 16'd2, 16'd1}, {2'd2, 2'd3, 2'd1, 2'd0}, LAT_NEAR};
    vecs[5] = '{"all_equal", {16'd5, 16'd5, 16'd5, 16'd5},
                {16'd5, 16'd5, 16'd5, 16'd5}, 8'hE4, LAT_SORTED};

    rst         = 1'b1;
    bus.start_i = 1'b0;
    bus.duty_i  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++) begin
      run_sort(vecs[i].duty, lat);
      check({vecs[i].name, "_latency"}, 64'(lat), 64'(vecs[i].exp_lat));
      check({vecs[i].name, "_sorted"},  bus.sorted_duty_o, vecs[i].exp_sorted);
      check({vecs[i].name, "_idx"},     64'(bus.sorted_idx_o), 64'(vecs[i].exp_idx));
      check({vecs[i].name, "_min"},     64'(bus.min_duty_o), 64'(vecs[i].exp_sorted[15:0]));
      check({vecs[i].name, "_max"},     64'(bus.max_duty_o), 64'(vecs[i].exp_sorted[63:48]));
      check({vecs[i].name, "_valid"},   64'(bus.valid_o), 64'd1);
      check({vecs[i].name, "_busy"},    64'(bus.busy_o), 64'd0);
    end

    // valid_o and the result persist while idle
    repeat (3) @(negedge clk);
    check("hold_valid", 64'(bus.valid_o), 64'd1);
    check("hold_done",  64'(bus.done_o), 64'd0);
    check("hold_idx",   64'(bus.sorted_idx_o), 64'(vecs[5].exp_idx));

    // start pulses in cycles 2 and 5 are ignored; cycle 6 is accepted
    @(negedge clk);
    bus.start_i = 1'b1;
    bus.duty_i  = vecs[0].duty;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    ndone = 0; first_done = -1; second_done = -1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (bus.done_o) begin
        ndone++;
        if (first_done < 0) begin
          first_done = c;
          check("ign_sorted", bus.sorted_duty_o, vecs[0].exp_sorted);
          check("ign_idx",    64'(bus.sorted_idx_o), 64'(vecs[0].exp_idx));
        end else begin
          second_done = c;
          check("second_sorted", bus.sorted_duty_o, vecs[1].exp_sorted);
          check("second_idx",    64'(bus.sorted_idx_o), 64'(vecs[1].exp_idx));
        end
      end
      if (c == 7) check("second_busy", 64'(bus.busy_o), 64'd1);
      bus.start_i = (c == 2 || c == 5 || c == 6);
      bus.duty_i  = (c == 6) ? vecs[1].duty : vecs[2].duty;
    end
    bus.start_i = 1'b0;
    check("ign_first_done",  64'(first_done),  64'd5);
    check("ign_second_done", 64'(second_done), 64'd11);
    check("ign_done_count",  64'(ndone),       64'd2);

    // reset in cycle 3 aborts the sort with no done_o
    repeat (2) @(negedge clk);
    bus.start_i = 1'b1;
    bus.duty_i  = vecs[1].duty;
    @(posedge clk);
    #1;
    bus.start_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("abort");
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.done_o) ndone++;
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    check("abort_idle",    64'(bus.busy_o), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, limit 200000 reached");
    $fatal(1);
  end
endmodule

// File: doc/pwm_duty_sorter.md
Name: pwm_duty_sorter

Overview:
- Sequential, parametrised successor to the two-input PWM min/max sorter.
- Sorts Channels compare (duty) values in ascending order and tags each with its source channel index.
- Sits between the PWM register file and the multi-edge PWM timer, which needs edge times ordered within one period.
- Uses an odd-even transposition network: one pass per clock and Channels/2 compare-swap cells in parallel.

Parameters:
- Resolution, 16, bit width of each duty value.
- Channels, 4, number of values sorted. Must be ≥2; an elaboration-time assertion enforces this.
- IdxW (localparam), $clog2(Channels), width of each channel index.

Ports:
- clk_i  in  1  system clock; all logic is on the rising edge.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  request to sort. Sampled only while idle.
- duty_i  in  Channels*Resolution  packed input values; channel c occupies bits [c*Resolution +: Resolution].
- busy_o  out  1  high from the cycle after an accepted start until done_o.
- done_o  out  1  one-cycle pulse when the result is complete.
- valid_o  out  1  high while the sorted outputs hold a completed result.
- sorted_duty_o  out  Channels*Resolution  ascending values; slot 0 holds the minimum.
- sorted_idx_o  out  Channels*IdxW  source channel index of each slot.
- min_duty_o  out  Resolution  equals slot 0 of sorted_duty_o.
- max_duty_o  out  Resolution  equals slot Channels-1 of sorted_duty_o.

Behaviour:
- Reset values:
  - State is IDLE.
  - busy_o, done_o and valid_o are 0.
  - sorted_duty_o, min_duty_o and max_duty_o are 0.
  - sorted_idx_o slot k holds k (identity order).
  - Pass counter is 0.
- FSM states are IDLE, SORT and DONE.
- IDLE:
  - On start_i=1, latch duty_i into the working registers, load the indices with identity order, clear valid_o, clear the pass counter, and go to SORT.
  - On start_i=0, hold.
- SORT:
  - Each cycle applies pass p = pass counter.
  - Even p compares pairs (0,1), (2,3), and so on. Odd p compares pairs (1,2), (3,4), and so on.
  - With odd Channels, an unpaired slot passes through unchanged.
  - A pair is swapped only if lower-slot value > upper-slot value (strictly). Equal values are never swapped, so the sort is stable: on ties, the lower channel index comes first.
  - The index travels with its value.
  - When p = Channels-1, go to DONE. Otherwise increment p.
- DONE:
  - done_o=1 and valid_o is set.
  - Return to IDLE next cycle.
  - valid_o holds until the next accepted start.
- Latency:
  - Start is accepted in cycle 0.
  - SORT occupies cycles 1..Channels.
  - done_o is high in cycle Channels+1 (cycle 5 for Channels=4).
  - Throughput is one sort per Channels+2 cycles.
- Outputs are driven directly from the working registers. Intermediate contents are visible while busy_o=1; consumers must qualify them with valid_o.
- start_i while busy_o=1 or in DONE is ignored, with no queueing.
- duty_i may change freely after the start cycle.
- Reset mid-sort aborts the sort, returns all outputs to their reset values, and produces no done_o pulse.
- Comparisons are unsigned, full Resolution width, with no arithmetic overflow.

Optional Feature:
- Macro: PWM_SORT_EARLY_EXIT_EN.
- When defined:
  - A swap flag is recorded per pass.
  - If pass p ≥ 1 and passes p and p-1 both had zero swaps, go to DONE after pass p.
  - The minimum latency is done_o in cycle 3.
  - An already-sorted input therefore finishes in 3 cycles instead of Channels+1.
- When undefined:
  - Always run exactly Channels passes.
  - Latency is fixed; no swap-flag logic is present.

Decomposition:
- Package pwm_sort_pkg holds:
  - the typedef enum logic [1:0] for state (IDLE, SORT, DONE);
  - a function computing IdxW.
- Sub-module pwm_cmp_swap:
  - Combinational compare-swap of one (value, index) pair, with strict-greater swap.
  - Outputs lo_val, lo_idx, hi_val, hi_idx and swapped.
  - Instantiated in a generate loop for even and odd pairings.

Test Plan:
- Channels=4, Resolution=16, duty = {ch0=300, ch1=100, ch2=200, ch3=100}, start_i at cycle 0:
  - done_o in cycle 5.
  - sorted_duty = {100, 100, 200, 300}, sorted_idx = {1, 3, 2, 0}.
  - min_duty_o=100, max_duty_o=300.
- Reverse input {400, 300, 200, 100} (worst case):
  - sorted = {100, 200, 300, 400}, idx = {3, 2, 1, 0}.
  - Latency is 5 cycles (both builds).
- start_i pulsed in cycles 2 and 5 of a running sort:
  - Ignored; exactly one done_o.
  - Next start is accepted in cycle 6.
- rst_i asserted in cycle 3 of a sort:
  - Next cycle shows busy_o=0, valid_o=0, outputs all zero, and idx in identity order.
  - No done_o follows.
- Edge values and duplicates: {0xFFFF, 0, 0xFFFF, 0} → sorted {0, 0, 0xFFFF, 0xFFFF}, idx {1, 3, 0, 2}.
- PWM_SORT_EARLY_EXIT_EN defined, input {10, 20, 30, 40}:
  - done_o in cycle 3, with the output equal to the input and identity idx.
  - Undefined build: done_o in cycle 5.
